matrix_result_readout_pcpi: RTL and testbench
=============================================

// Module: matrix_result_readout_pcpi
// PURPOSE
//  Downstream stage of the fused 3x3 systolic matrix unit.
//  - Captures the 3x3 accumulator results and their 9 threshold flags on a one-cycle valid pulse.
//  - Clamps each result to OUT_W bits and serves it to the CPU over PCPI custom-0 read instructions.
//  - When a read arrives before results exist, stalls the CPU (pcpi_wait) until capture or timeout.
// PARAMETERS
//  OUT_W        16   width of a saturated element returned to CPU (sign-extended to 32)
//  TIMEOUT_CYC  64   max cycles spent in WAIT_RES before an empty response
// PORTS
//  clk         in   1    clock
//  rst         in   1    synchronous active-high reset
//  res_valid   in   1    one-cycle pulse: res_data/res_flags valid this cycle
//  res_data    in   288  9 x signed 32b accumulators, element k at [32k+31:32k], k=row*3+col
//  res_flags   in   9    threshold-compare flags, bit k = element k
//  pcpi_valid  in   1    PCPI request
//  pcpi_insn   in   32   instruction; opcode [6:0], funct3 [14:12], index [11:7]
//  pcpi_wr     out  1    rd write-enable, meaningful only with pcpi_ready
//  pcpi_rd     out  32   result data
//  pcpi_wait   out  1    stall CPU while request pending
//  pcpi_ready  out  1    one-cycle completion pulse
//  sat_count   out  4    number of elements clamped in last capture (0..9)
// BEHAVIOUR
//  - Reset: all outputs 0. buf_full=0, buffers cleared, FSM=IDLE.
//  - Accepted insn: opcode 7'b0001011 with funct3 010 RD_ELEM, 011 RD_FLAGS, 110 CLEAR.
//  - Other funct3 values: ignored, no response (owned by the matrix unit).
//  - Capture on res_valid:
//    - buf_data[k] = clamp(res_data[k]) into [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    - buf_flags = res_flags; sat_count = number of clamped elements; buf_full=1.
//  - FSM states IDLE, WAIT_RES, RESP, GAP:
//    - IDLE, accepted insn:
//      - CLEAR, or a read with buf_full=1 -> RESP.
//      - Read with buf_full=0 -> WAIT_RES, pcpi_wait=1, timer loaded to 0.
//    - WAIT_RES: pcpi_wait=1, timer increments each cycle.
//      - res_valid -> RESP; the response uses the data captured that cycle.
//      - timer==TIMEOUT_CYC-1 -> RESP with timeout flag set.
//    - RESP: exactly one cycle, pcpi_ready=1 -> GAP.
//      - RD_ELEM: pcpi_wr=1, pcpi_rd = sign-extended buf_data[index]; index>8 gives rd=0.
//      - RD_FLAGS: pcpi_wr=1, pcpi_rd = {23'b0, buf_flags}.
//      - CLEAR: pcpi_wr=0, clears buf_full/flags/sat_count in this cycle.
//      - Timeout: pcpi_wr=0, pcpi_rd=0.
//    - GAP: one cycle, ignores pcpi_valid (CPU still dropping valid) -> IDLE.
//  - Latency: read on a full buffer accepted in cycle N gives pcpi_ready in N+1.
//  - Response data is registered at RESP entry; a capture during RESP/GAP does not alter it.
//  - res_valid in the same cycle as a CLEAR response: clear first, then capture (buf_full=1 after).
//  - res_valid in IDLE with no request: capture only; a later capture overwrites all 9 elements.
//  - rst asserted mid-transaction: next cycle IDLE, all outputs 0; the pending CPU request is dropped.
// CONFIGURATION
//  RESULT_RELU_EN defined:
//    - Negative accumulators become 0 before the clamp; sat_count counts upper clamps only.
//    - RD_ELEM is then zero-extended.
//  RESULT_RELU_EN undefined: signed clamp and sign-extension as above.
// STRUCTURE
//  Package matrix_pcpi_pkg:
//    - OPC_CUSTOM0, F3_WRITE, F3_RD_ELEM, F3_RD_FLAGS, F3_CLEAR, F3_START.
//    - MAT_N=3, MAT_ELEMS=9, FSM state enum.
//  Sub-module sat_clamp (combinational 32->OUT_W clamp + clamped flag), instantiated 9x.
//  Top holds FSM, timer, capture registers and response mux.
// TESTING
//  - Capture: res_data k0=100, k4=-40000, k8=70000, flags=9'h1A5.
//    - RD_ELEM idx0/4/8 -> rd 100, 0xFFFF8000, 0x00007FFF, pcpi_ready one cycle after valid.
//    - sat_count=2.
//  - Empty read, res_valid 10 cycles later with k3=-5:
//    - pcpi_wait high 10 cycles, then ready with rd=0xFFFFFFFB.
//  - Empty read, no res_valid -> pcpi_ready at cycle 64 with pcpi_wr=0, rd=0.
//  - RD_FLAGS after capture -> rd=0x000001A5.
//    - CLEAR then RD_FLAGS -> stall path.
//    - CLEAR with a simultaneous res_valid -> buf_full=1 and new data readable.
//  - RD_ELEM idx=12 -> rd=0, wr=1.
//    - rst pulsed while in WAIT_RES -> all outputs 0 next cycle, FSM IDLE.
//  - With RESULT_RELU_EN, k4=-40000 -> rd=0, sat_count=1.

Source files
------------

// File: rtl/matrix_result_readout_pcpi_pkg.sv
// Shared opcodes, geometry and FSM state type for the matrix result readout PCPI stage.
package matrix_pcpi_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_WRITE    = 3'b000;
  localparam logic [2:0] F3_START    = 3'b001;
  localparam logic [2:0] F3_RD_ELEM  = 3'b010;
  localparam logic [2:0] F3_RD_FLAGS = 3'b011;
  localparam logic [2:0] F3_CLEAR    = 3'b110;

  localparam int MAT_N     = 3;
  localparam int MAT_ELEMS = MAT_N * MAT_N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RES,
    ST_RESP,
    ST_GAP
  } state_e;

  // WRITE/START belong to the matrix unit itself, so only the readout functions answer here.
  function automatic logic is_accepted(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_CUSTOM0) &&
           ((funct3 == F3_RD_ELEM) || (funct3 == F3_RD_FLAGS) || (funct3 == F3_CLEAR));
  endfunction

endpackage

// File: rtl/matrix_result_readout_pcpi_if.sv
// PCPI request/response bundle between the CPU (master) and the readout stage (slave).
interface matrix_result_readout_pcpi_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

endinterface

// File: rtl/matrix_result_readout_pcpi_sat_clamp.sv
// Combinational clamp of a signed 32-bit accumulator to OUT_W bits plus a clamped flag.
// RESULT_RELU_EN: negatives become 0 first and only upper clamps are flagged.
module sat_clamp #(
  parameter int OUT_W = 16
) (
  input  logic signed [31:0]      acc,
  output logic        [OUT_W-1:0] q,
  output logic                    clamped
);

  localparam logic signed [31:0] MAX_V = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] MIN_V = -(32'sd1 <<< (OUT_W - 1));

  always_comb begin
    q       = acc[OUT_W-1:0];
    clamped = 1'b0;
`ifdef RESULT_RELU_EN
    if (acc < 32'sd0) begin
      q = '0;
    end else if (acc > MAX_V) begin
      q       = MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end
`else
    if (acc > MAX_V) begin
      q       = MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end else if (acc < MIN_V) begin
      q       = MIN_V[OUT_W-1:0];
      clamped = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/matrix_result_readout_pcpi.sv
// Captures 3x3 matrix results, clamps them and serves them over PCPI custom-0 reads.
// RESULT_RELU_EN selects ReLU + zero-extension instead of signed clamp + sign-extension.
module matrix_result_readout_pcpi
  import matrix_pcpi_pkg::*;
#(
  parameter int OUT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  matrix_result_readout_pcpi_if.slave    pcpi,
  input  logic                           res_valid,
  input  logic [32*MAT_ELEMS-1:0]        res_data,
  input  logic [MAT_ELEMS-1:0]           res_flags,
  output logic [3:0]                     sat_count
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           op_q, op_d;
  logic [4:0]           idx_q, idx_d;
  logic                 resp_wr_q, resp_wr_d;
  logic [31:0]          resp_rd_q, resp_rd_d;

  logic [OUT_W-1:0]     clamp_val [MAT_ELEMS];
  logic [MAT_ELEMS-1:0] clamp_hit;
  logic [3:0]           sat_next;

  logic [OUT_W-1:0]     buf_data [MAT_ELEMS];
  logic [MAT_ELEMS-1:0] buf_flags;
  logic                 buf_full;

  logic                 accept;
  logic [2:0]           insn_f3;
  logic [4:0]           insn_idx;
  logic [2:0]           sel_f3;
  logic [4:0]           sel_idx;
  logic [OUT_W-1:0]     sel_elem;
  logic [31:0]          elem_word;
  logic [31:0]          flags_word;
  logic [31:0]          resp_word;
  logic                 unused_insn_hi;

  assign insn_f3        = pcpi.pcpi_insn[14:12];
  assign insn_idx       = pcpi.pcpi_insn[11:7];
  assign unused_insn_hi = ^pcpi.pcpi_insn[31:15];
  assign accept         = pcpi.pcpi_valid && is_accepted(pcpi.pcpi_insn[6:0], insn_f3);

  for (genvar k = 0; k < MAT_ELEMS; k++) begin : g_clamp
    sat_clamp #(.OUT_W(OUT_W)) u_clamp (
      .acc     (res_data[32*k +: 32]),
      .q       (clamp_val[k]),
      .clamped (clamp_hit[k])
    );
  end

  always_comb begin
    sat_next = '0;
    for (int k = 0; k < MAT_ELEMS; k++) begin
      sat_next = sat_next + 4'(clamp_hit[k]);
    end
  end

  // A capture in the same cycle counts as present data, so responses look through to it.
  always_comb begin
    sel_f3    = (state_q == ST_IDLE) ? insn_f3  : op_q;
    sel_idx   = (state_q == ST_IDLE) ? insn_idx : idx_q;
    sel_elem  = '0;
    elem_word = '0;
    if (sel_idx < 5'(MAT_ELEMS)) begin
      sel_elem = res_valid ? clamp_val[sel_idx[3:0]] : buf_data[sel_idx[3:0]];
`ifdef RESULT_RELU_EN
      elem_word = 32'(sel_elem);
`else
      elem_word = 32'($signed(sel_elem));
`endif
    end
    flags_word = {23'b0, (res_valid ? res_flags : buf_flags)};
    resp_word  = (sel_f3 == F3_RD_FLAGS) ? flags_word : elem_word;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    op_d      = op_q;
    idx_d     = idx_q;
    resp_wr_d = resp_wr_q;
    resp_rd_d = resp_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = insn_f3;
          idx_d = insn_idx;
          if (insn_f3 == F3_CLEAR) begin
            state_d   = ST_RESP;
            resp_wr_d = 1'b0;
            resp_rd_d = '0;
          end else if (buf_full || res_valid) begin
            state_d   = ST_RESP;
            resp_wr_d = 1'b1;
            resp_rd_d = resp_word;
          end else begin
            state_d = ST_WAIT_RES;
            timer_d = '0;
          end
        end
      end
      ST_WAIT_RES: begin
        if (res_valid) begin
          state_d   = ST_RESP;
          resp_wr_d = 1'b1;
          resp_rd_d = resp_word;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_RESP;
          resp_wr_d = 1'b0;
          resp_rd_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      resp_wr_q <= 1'b0;
      resp_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      resp_wr_q <= resp_wr_d;
      resp_rd_q <= resp_rd_d;
    end
  end

  // Clear is applied before capture so a coincident res_valid leaves the buffer full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAT_ELEMS; k++) begin
        buf_data[k] <= '0;
      end
      buf_flags <= '0;
      sat_count <= '0;
      buf_full  <= 1'b0;
    end else begin
      if ((state_q == ST_RESP) && (op_q == F3_CLEAR)) begin
        buf_flags <= '0;
        sat_count <= '0;
        buf_full  <= 1'b0;
      end
      if (res_valid) begin
        for (int k = 0; k < MAT_ELEMS; k++) begin
          buf_data[k] <= clamp_val[k];
        end
        buf_flags <= res_flags;
        sat_count <= sat_next;
        buf_full  <= 1'b1;
      end
    end
  end

  assign pcpi.pcpi_ready = (state_q == ST_RESP);
  assign pcpi.pcpi_wait  = (state_q == ST_WAIT_RES);
  assign pcpi.pcpi_wr    = (state_q == ST_RESP) && resp_wr_q;
  assign pcpi.pcpi_rd    = (state_q == ST_RESP) ? resp_rd_q : '0;

endmodule

// File: tb/tb_matrix_result_readout_pcpi.sv
// Directed self-checking bench for matrix_result_readout_pcpi (honours RESULT_RELU_EN).
module tb_matrix_result_readout_pcpi;
  import matrix_pcpi_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic [287:0] res_data;
  logic [8:0]   res_flags;
  logic [3:0]   sat_count;
  int           checks = 0;
  int           errors = 0;
  int           wait_cnt;

`ifdef RESULT_RELU_EN
  localparam logic [31:0] EXP_K4   = 32'h0000_0000;
  localparam logic [31:0] EXP_SAT1 = 32'd1;
  localparam logic [31:0] EXP_K3   = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_K4   = 32'hFFFF_8000;
  localparam logic [31:0] EXP_SAT1 = 32'd2;
  localparam logic [31:0] EXP_K3   = 32'hFFFF_FFFB;
`endif

  always #5 clk = ~clk;

  matrix_result_readout_pcpi_if pcpi_bus ();

  matrix_result_readout_pcpi dut (
    .clk       (clk),
    .rst       (rst),
    .pcpi      (pcpi_bus),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_flags (res_flags),
    .sat_count (sat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [4:0] idx);
    return {17'b0, f3, idx, OPC_CUSTOM0};
  endfunction

  task automatic apply_stimulus(input logic valid, input logic [31:0] insn);
    pcpi_bus.pcpi_valid = valid;
    pcpi_bus.pcpi_insn  = insn;
  endtask

  task automatic set_elem(input int k, input logic [31:0] v);
    res_data[32*k +: 32] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(pcpi_bus.pcpi_ready), 32'd0);
    check_output({tag, "_wait"},  32'(pcpi_bus.pcpi_wait),  32'd0);
    check_output({tag, "_wr"},    32'(pcpi_bus.pcpi_wr),    32'd0);
    check_output({tag, "_rd"},    pcpi_bus.pcpi_rd,         32'd0);
  endtask

  // Request on a full buffer: ready must come exactly one cycle after valid.
  task automatic do_read(input string tag, input logic [2:0] f3, input logic [4:0] idx,
                         input logic [31:0] exp_rd, input logic exp_wr);
    apply_stimulus(1'b1, mk_insn(f3, idx));
    tick();
    check_output({tag, "_ready"}, 32'(pcpi_bus.pcpi_ready), 32'd1);
    check_output({tag, "_wr"},    32'(pcpi_bus.pcpi_wr),    32'(exp_wr));
    check_output({tag, "_rd"},    pcpi_bus.pcpi_rd,         exp_rd);
    apply_stimulus(1'b0, 32'h0);
    tick();
    check_output({tag, "_gap_ready"}, 32'(pcpi_bus.pcpi_ready), 32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    res_flags = '0;
    apply_stimulus(1'b0, 32'h0);
    repeat (2) tick();
    check_idle_outputs("reset");
    check_output("reset_sat", 32'(sat_count), 32'd0);
    rst = 1'b0;
    tick();

    // Matrix-unit functions must get no response from this stage.
    apply_stimulus(1'b1, mk_insn(F3_START, 5'd0));
    tick();
    tick();
    check_output("start_ignored_ready", 32'(pcpi_bus.pcpi_ready), 32'd0);
    check_output("start_ignored_wait",  32'(pcpi_bus.pcpi_wait),  32'd0);
    apply_stimulus(1'b1, mk_insn(F3_WRITE, 5'd1));
    tick();
    check_output("write_ignored_ready", 32'(pcpi_bus.pcpi_ready), 32'd0);
    apply_stimulus(1'b0, 32'h0);
    tick();

    set_elem(0, 32'd100);
    set_elem(4, -40000);
    set_elem(8, 32'd70000);
    res_flags = 9'h1A5;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check_output("capture_sat", 32'(sat_count), EXP_SAT1);

    do_read("rd_idx0",  F3_RD_ELEM,  5'd0,  32'd100,        1'b1);
    do_read("rd_idx4",  F3_RD_ELEM,  5'd4,  EXP_K4,         1'b1);
    do_read("rd_idx8",  F3_RD_ELEM,  5'd8,  32'h0000_7FFF,  1'b1);
    do_read("rd_flags", F3_RD_FLAGS, 5'd0,  32'h0000_01A5,  1'b1);
    do_read("rd_idx12", F3_RD_ELEM,  5'd12, 32'h0,          1'b1);

    do_read("clear", F3_CLEAR, 5'd0, 32'h0, 1'b0);
    check_output("clear_sat", 32'(sat_count), 32'd0);

    // Empty read stalls until a capture arrives ten cycles after the request.
    res_data  = '0;
    set_elem(3, -5);
    res_flags = 9'h008;
    wait_cnt  = 0;
    apply_stimulus(1'b1, mk_insn(F3_RD_ELEM, 5'd3));
    tick();
    if (pcpi_bus.pcpi_wait) wait_cnt++;
    repeat (9) begin
      tick();
      if (pcpi_bus.pcpi_wait) wait_cnt++;
    end
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check_output("stall_wait_cycles", 32'(wait_cnt), 32'd10);
    check_output("stall_ready", 32'(pcpi_bus.pcpi_ready), 32'd1);
    check_output("stall_wr",    32'(pcpi_bus.pcpi_wr),    32'd1);
    check_output("stall_rd",    pcpi_bus.pcpi_rd,         EXP_K3);
    check_output("stall_wait_low", 32'(pcpi_bus.pcpi_wait), 32'd0);
    apply_stimulus(1'b0, 32'h0);
    tick();
    tick();
    check_output("stall_sat", 32'(sat_count), 32'd0);

    // CLEAR response coinciding with a capture: buffer must end up full with new data.
    apply_stimulus(1'b1, mk_insn(F3_CLEAR, 5'd0));
    tick();
    check_output("clrcap_ready", 32'(pcpi_bus.pcpi_ready), 32'd1);
    check_output("clrcap_wr",    32'(pcpi_bus.pcpi_wr),    32'd0);
    apply_stimulus(1'b0, 32'h0);
    res_data  = '0;
    set_elem(1, 32'd1234);
    res_flags = 9'h0F0;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    do_read("clrcap_idx1",  F3_RD_ELEM,  5'd1, 32'd1234, 1'b1);
    do_read("clrcap_flags", F3_RD_FLAGS, 5'd0, 32'h0F0,  1'b1);

    // CLEAR then RD_FLAGS with no capture: timeout empty response.
    do_read("clear2", F3_CLEAR, 5'd0, 32'h0, 1'b0);
    apply_stimulus(1'b1, mk_insn(F3_RD_FLAGS, 5'd0));
    tick();
    wait_cnt = 0;
    while (pcpi_bus.pcpi_wait && wait_cnt < 200) begin
      wait_cnt++;
      tick();
    end
    check_output("timeout_wait_cycles", 32'(wait_cnt), 32'd64);
    check_output("timeout_ready", 32'(pcpi_bus.pcpi_ready), 32'd1);
    check_output("timeout_wr",    32'(pcpi_bus.pcpi_wr),    32'd0);
    check_output("timeout_rd",    pcpi_bus.pcpi_rd,         32'd0);
    apply_stimulus(1'b0, 32'h0);
    tick();
    tick();

    // Reset while stalled drops the request.
    apply_stimulus(1'b1, mk_insn(F3_RD_ELEM, 5'd0));
    tick();
    repeat (3) tick();
    check_output("pre_rst_wait", 32'(pcpi_bus.pcpi_wait), 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    check_output("mid_rst_sat", 32'(sat_count), 32'd0);
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0);
    tick();
    check_output("post_rst_wait", 32'(pcpi_bus.pcpi_wait), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
